// File: rtl/barrel_shift_pkg.sv
// Shared constants for the shared barrel-shifter scheduler and its shifter datapath.
package barrel_shift_pkg;
  localparam int   DATA_W        = 8;
  localparam int   N_W           = 3;
  localparam logic DIR_LEFT      = 1'b1;
  localparam logic DIR_RIGHT     = 1'b0;
  localparam int   N_REQ_DEFAULT = 4;
endpackage

// File: rtl/barrel_shift_8bit.sv
// 8-bit logical barrel shifter, zero fill; Lr=1 shifts left, Lr=0 shifts right.
module barrel_shift_8bit
  import barrel_shift_pkg::*;
(
  output logic [7:0] out,
  input  logic [7:0] in,
  input  logic       Lr,
  input  logic [2:0] n
);
  logic       left;
  logic [7:0] s1;
  logic [7:0] s2;

  assign left = (Lr == DIR_LEFT);

  // Three log stages: shift by 1, 2 and 4 selected by the bits of n.
  always_comb begin
    s1  = n[0] ? (left ? {in[6:0], 1'b0} : {1'b0, in[7:1]}) : in;
    s2  = n[1] ? (left ? {s1[5:0], 2'b00} : {2'b00, s1[7:2]}) : s1;
    out = n[2] ? (left ? {s2[3:0], 4'b0000} : {4'b0000, s2[7:4]}) : s2;
  end
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request scanning cyclically from ptr.
module rr_arbiter #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx
);
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (en && !found && req[IDW'(j)]) begin
        found          = 1'b1;
        gnt[IDW'(j)]   = 1'b1;
        idx            = IDW'(j);
      end
    end
  end
endmodule

// File: rtl/barrel_shift_sched.sv
// Round-robin scheduler sharing one 8-bit barrel shifter among N_REQ requesters,
// with a single registered, ID-tagged result stage.
module barrel_shift_sched
  import barrel_shift_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEFAULT,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [DATA_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_lr,
  input  logic [N_W*N_REQ-1:0]    req_n,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [DATA_W-1:0]       res_data,
  output logic [ID_W-1:0]         res_id
);
  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic [ID_W-1:0]   id_p1;
  logic [ID_W-1:0]   rr_ptr;

  logic              accept;
  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              fire;
  logic [DATA_W-1:0] sel_data;
  logic              sel_lr;
  logic [N_W-1:0]    sel_n;
  logic [DATA_W-1:0] shifted;
  logic [ID_W-1:0]   ptr_next;

  assign accept = !vld_p1 || res_ready;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .en  (accept),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  // The async reset clears vld_p1, which would otherwise open accept during reset.
  assign req_ready = rst_n ? gnt : '0;
  assign fire      = |req_ready;

  always_comb begin
    sel_data = '0;
    sel_lr   = DIR_RIGHT;
    sel_n    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_data = req_data[i*DATA_W +: DATA_W];
        sel_lr   = req_lr[i];
        sel_n    = req_n[i*N_W +: N_W];
      end
    end
  end

  barrel_shift_8bit u_shift (
    .out (shifted),
    .in  (sel_data),
    .Lr  (sel_lr),
    .n   (sel_n)
  );

  assign ptr_next = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // ---- stage p1: registered result, overwritten on a grant, cleared on drain ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      id_p1   <= '0;
      rr_ptr  <= '0;
    end else if (fire) begin
      vld_p1  <= 1'b1;
      data_p1 <= shifted;
      id_p1   <= gnt_idx;
      rr_ptr  <= ptr_next;
    end else if (res_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign res_valid = vld_p1;
  assign res_data  = data_p1;
  assign res_id    = id_p1;
endmodule

// File: tb/tb_barrel_shift_sched.sv
// Self-checking bench for barrel_shift_sched: directed scenarios plus randomized traffic
// compared against an arithmetic reference model of the scheduler.
module tb_barrel_shift_sched;
  localparam int N    = 4;
  localparam int ID_W = $clog2(N);

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_lr;
  logic [3*N-1:0] req_n;
  logic           res_valid;
  logic           res_ready;
  logic [7:0]     res_data;
  logic [ID_W-1:0] res_id;

  int checks = 0;
  int errors = 0;

  // reference model state
  int              m_ptr;
  logic            m_vld;
  logic [7:0]      m_data;
  logic [ID_W-1:0] m_id;

  always #5 clk = ~clk;

  barrel_shift_sched #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_lr    (req_lr),
    .req_n     (req_n),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id)
  );

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic lr, input int n);
    int v;
    if (lr) v = (int'(d) * (1 << n)) % 256;
    else    v = int'(d) / (1 << n);
    return v[7:0];
  endfunction

  function automatic int m_pick();
    if (m_vld && !res_ready) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (((req_valid >> i) & 1) != 0) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    int g;
    g = m_pick();
    if (g < 0) return '0;
    return N'(1) << g;
  endfunction

  function automatic logic [7:0] req_result(input int i);
    return ref_shift(req_data[8*i +: 8], ((req_lr >> i) & 1) != 0, int'(req_n[3*i +: 3]));
  endfunction

  task automatic m_edge();
    int g;
    g = m_pick();
    if (g >= 0) begin
      m_data = req_result(g);
      m_id   = ID_W'(g);
      m_vld  = 1'b1;
      m_ptr  = (g + 1) % N;
    end else if (res_ready) begin
      m_vld = 1'b0;
    end
  endtask

  task automatic m_reset();
    m_ptr  = 0;
    m_vld  = 1'b0;
    m_data = '0;
    m_id   = '0;
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic lr, input int n);
    req_valid = req_valid | (N'(1) << i);
    if (lr) req_lr = req_lr | (N'(1) << i);
    else    req_lr = req_lr & ~(N'(1) << i);
    req_data[8*i +: 8] = d;
    req_n[3*i +: 3]    = 3'(n);
  endtask

  task automatic drop_req(input int i);
    req_valid = req_valid & ~(N'(1) << i);
  endtask

  task automatic clr_all();
    req_valid = '0;
    req_lr    = '0;
    req_data  = '0;
    req_n     = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    res_ready = 1'b1;
    clr_all();
    req_valid = '1;
    m_reset();
    #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", res_valid); end
    checks++; if (res_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h expected 00", res_data); end
    checks++; if (res_id !== '0) begin errors++; $display("FAIL reset_id got %0d expected 0", res_id); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got %b expected 0000", req_ready); end
    clr_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    clr_all();
    res_ready = 1'b1;
    set_req(0, 8'hB7, 1'b1, 3);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b expected 0001", req_ready); end
    m_edge();
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b expected 1", res_valid); end
    checks++; if (res_data !== 8'hB8) begin errors++; $display("FAIL single_data got %h expected b8", res_data); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL single_id got %0d expected 0", res_id); end
    clr_all();
    m_edge();
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid got %b expected 0", res_valid); end
    checks++; if (res_data !== 8'hB8) begin errors++; $display("FAIL single_drain_hold got %h expected b8", res_data); end
  endtask

  task automatic test_shift_modes();
    int         ids   [2] = '{2, 1};
    logic       lrs   [2] = '{1'b0, 1'b0};
    int         ns    [2] = '{2, 0};
    logic [7:0] exps  [2] = '{8'h2D, 8'hB7};
    for (int c = 0; c < 2; c++) begin
      clr_all();
      res_ready = 1'b1;
      set_req(ids[c], 8'hB7, lrs[c], ns[c]);
      #1;
      checks++; if (req_ready !== (N'(1) << ids[c])) begin errors++; $display("FAIL shift_ready[%0d] got %b expected %b", c, req_ready, N'(1) << ids[c]); end
      m_edge();
      @(posedge clk); #1;
      checks++; if (res_data !== exps[c]) begin errors++; $display("FAIL shift_data[%0d] got %h expected %h", c, res_data, exps[c]); end
      checks++; if (res_id !== ID_W'(ids[c])) begin errors++; $display("FAIL shift_id[%0d] got %0d expected %0d", c, res_id, ids[c]); end
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL shift_valid[%0d] got %b expected 1", c, res_valid); end
    end
    clr_all();
  endtask

  task automatic test_round_robin();
    int order [9] = '{0, 1, 2, 3, 0, 1, 3, 1, 3};
    logic [7:0] e;
    clr_all();
    rst_n = 1'b0; #1; rst_n = 1'b1;
    m_reset();
    res_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 8'($urandom), 1'($urandom), int'($urandom % 8));
    for (int c = 0; c < 9; c++) begin
      if (c == 5) begin
        clr_all();
        set_req(1, 8'($urandom), 1'($urandom), int'($urandom % 8));
        set_req(3, 8'($urandom), 1'($urandom), int'($urandom % 8));
      end
      #1;
      checks++; if (req_ready !== (N'(1) << order[c])) begin errors++; $display("FAIL rr_ready[%0d] got %b expected %b", c, req_ready, N'(1) << order[c]); end
      e = req_result(order[c]);
      m_edge();
      @(posedge clk); #1;
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got %b expected 1", c, res_valid); end
      checks++; if (res_id !== ID_W'(order[c])) begin errors++; $display("FAIL rr_id[%0d] got %0d expected %0d", c, res_id, order[c]); end
      checks++; if (res_data !== e) begin errors++; $display("FAIL rr_data[%0d] got %h expected %h", c, res_data, e); end
      set_req(order[c], 8'($urandom), 1'($urandom), int'($urandom % 8));
    end
    clr_all();
  endtask

  task automatic test_backpressure();
    logic [7:0] e0;
    logic [7:0] e2;
    clr_all();
    res_ready = 1'b1;
    set_req(0, 8'($urandom), 1'b1, int'($urandom % 8));
    set_req(2, 8'($urandom), 1'b0, int'($urandom % 8));
    e0 = req_result(0);
    e2 = req_result(2);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_first_ready got %b expected 0001", req_ready); end
    m_edge();
    @(posedge clk); #1;
    drop_req(0);
    res_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready !== '0) begin errors++; $display("FAIL bp_stall_ready[%0d] got %b expected 0000", c, req_ready); end
      m_edge();
      @(posedge clk); #1;
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_valid[%0d] got %b expected 1", c, res_valid); end
      checks++; if (res_data !== e0) begin errors++; $display("FAIL bp_stall_data[%0d] got %h expected %h", c, res_data, e0); end
      checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL bp_stall_id[%0d] got %0d expected 0", c, res_id); end
    end
    res_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready got %b expected 0100", req_ready); end
    m_edge();
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_release_valid got %b expected 1", res_valid); end
    checks++; if (res_id !== 2'd2) begin errors++; $display("FAIL bp_release_id got %0d expected 2", res_id); end
    checks++; if (res_data !== e2) begin errors++; $display("FAIL bp_release_data got %h expected %h", res_data, e2); end
    drop_req(2);
  endtask

  task automatic test_async_reset();
    clr_all();
    set_req(1, 8'($urandom), 1'b1, 1);
    res_ready = 1'b0;
    #1;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL ar_stall_ready got %b expected 0000", req_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b expected 0", res_valid); end
    checks++; if (res_data !== 8'h00) begin errors++; $display("FAIL ar_data got %h expected 00", res_data); end
    checks++; if (res_id !== '0) begin errors++; $display("FAIL ar_id got %0d expected 0", res_id); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL ar_ready got %b expected 0000", req_ready); end
    m_reset();
    #2;
    rst_n = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 8'($urandom), 1'($urandom), int'($urandom % 8));
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL ar_first_ready got %b expected 0001", req_ready); end
    m_edge();
    @(posedge clk); #1;
    checks++; if (res_id !== 2'd0 || res_valid !== 1'b1) begin errors++; $display("FAIL ar_first_grant got id %0d valid %b expected id 0 valid 1", res_id, res_valid); end
    req_valid = req_valid & ~4'b0001;
  endtask

  task automatic test_random();
    logic [N-1:0] exp_rdy;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (((req_valid >> i) & 1) == 0 && ($urandom % 2) == 1)
          set_req(i, 8'($urandom), 1'($urandom), int'($urandom % 8));
      res_ready = ($urandom % 4) != 0;
      #1;
      exp_rdy = m_ready();
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready[%0d] got %b expected %b", c, req_ready, exp_rdy); end
      m_edge();
      @(posedge clk); #1;
      checks++;
      if (res_valid !== m_vld || res_data !== m_data || res_id !== m_id) begin
        errors++;
        $display("FAIL rand_result[%0d] got v%b d%h id%0d expected v%b d%h id%0d",
                 c, res_valid, res_data, res_id, m_vld, m_data, m_id);
      end
      for (int i = 0; i < N; i++)
        if (((exp_rdy >> i) & 1) != 0) drop_req(i);
    end
    clr_all();
  endtask

  initial begin
    test_reset();
    test_single();
    test_shift_modes();
    test_round_robin();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/barrel_shift_sched.md
Name: barrel_shift_sched

Overview:
- Shares one 8-bit logical barrel shifter among N_REQ requesters.
- Each requester presents data, direction and amount under a valid/ready handshake; the block grants one requester per cycle in round-robin order.
- The shift result is registered into a single output stage tagged with the requester ID.
- Sits between client blocks and the shifter datapath; full throughput of one operation per cycle when the consumer does not stall.

Parameters:
- N_REQ, 4, number of requesters; legal 2..8.
- ID_W, derived localparam = clog2(N_REQ), width of the requester ID.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_data  in  8*N_REQ  operand; requester i uses bits [8i+7:8i].
- req_lr  in  N_REQ  direction; 1 = left, 0 = right.
- req_n  in  3*N_REQ  shift amount 0..7; requester i uses bits [3i+2:3i].
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accept.
- res_data  out  8  shifted result.
- res_id  out  ID_W  index of the requester that produced res_data.

Behaviour:
- Reset (async, rst_n=0): res_valid=0, res_data=0, res_id=0, rr_ptr=0; req_ready forced to all-zero while rst_n=0. Reset mid-stream discards the held result, and no handshake completes.
- Shift semantics are logical with zero fill. Lr=1 gives (data<<n)&0xFF; Lr=0 gives data>>n; n=0 passes data through.
- accept = !res_valid || res_ready, i.e. the output stage is empty or draining this cycle.
- Grant (combinational): the first i with req_valid[i]=1, scanning cyclically from rr_ptr. There is no grant if no request is valid or accept=0.
- req_ready[i] = accept && grant==i. Paths valid->ready and res_ready->req_ready are combinational by design.
- A requester holds valid, data, lr and n stable until it sees ready. Dropping valid before that is illegal.
- Handshake on req i at edge k:
  - res_data <= shift(req_data_i, req_lr[i], req_n_i)
  - res_id <= i
  - res_valid <= 1
  - rr_ptr <= (i+1) mod N_REQ, with wrap from N_REQ-1 to 0.
- Latency: one cycle. The result is visible right after the accepting edge.
- Result drained (res_valid && res_ready) with no new grant in the same cycle: res_valid <= 0, and res_data/res_id hold their last values.
- Drain and new grant in the same cycle: the output is overwritten with the new result and res_valid stays 1, giving zero bubbles.
- Stall (res_valid=1, res_ready=0): res_data and res_id hold stable, all req_ready=0, and rr_ptr holds.
- rr_ptr changes only on a handshake. Idle cycles do not advance it.
- Fairness: with all requesters continuously valid and no stalls, each is granted exactly once per N_REQ cycles.

Decomposition:
- Package barrel_shift_pkg holds:
  - DATA_W=8 and N_W=3
  - DIR_LEFT=1'b1 and DIR_RIGHT=1'b0
  - the default N_REQ.
- Natural sub-module: rr_arbiter. Inputs are req vector, ptr and enable; outputs are a one-hot grant and the encoded index. It is reusable across the codebase.
- The shift itself is one instance of the team's existing barrel_shift_8bit, port order (out, in, Lr, n), fed through a mux from the granted requester.

Test Plan:
- Single request: req0 valid, data=0xB7, lr=1, n=3, res_ready=1 -> one cycle later res_valid=1, res_data=0xB8, res_id=0; then res_valid=0.
- Right shift and passthrough:
  - req2 data=0xB7, lr=0, n=2 -> res_data=0x2D, res_id=2.
  - req1 data=0xB7, n=0 -> res_data=0xB7.
- Round-robin: all four valid, distinct data, res_ready=1 -> results on consecutive cycles with res_id 0,1,2,3,0 and no bubbles. Then only req1 and req3 valid with rr_ptr=1 -> ids 1,3,1,3.
- Backpressure: result pending and res_ready=0 for 3 cycles -> res_data/res_id stable, req_ready=0. On res_ready=1 the next grant lands on the same edge and res_valid never drops.
- Async reset: assert rst_n=0 mid-stall -> res_valid=0, res_data=0, req_ready=0 immediately. After release, the first grant goes to req0.
